// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one UART transmit line among NREQ byte requesters. A round-robin
//   arbiter moves one requester's byte into a single holding register. A
//   frame sequencer then shifts that byte out as start / 8 data (LSB first) /
//   STOP_BITS stop bits. Every bit boundary is paced by baud_tick.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   baud_tick  one-cycle pulse per bit period
//   req        per-requester byte request (held until granted)
//   data       requester i's byte on [8i+7:8i]
//   gnt        one-hot, one-cycle grant pulse (registered)
//   tx         serial line, idles high
//   busy       holding register full or frame in progress
//   cur_id     id of the requester whose byte is shifting
module uart_tx_scheduler #(
  parameter int NREQ      = 4,
  parameter int STOP_BITS = 1,
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic              tx,
  output logic              busy,
  output logic [IW-1:0]     cur_id
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [0:0] STOP_LAST = 1'(STOP_BITS - 1);

  logic [1:0]      state_q, state_d;
  logic            tx_q, tx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   cur_id_q, cur_id_d;
  logic [7:0]      hold_q, hold_d;
  logic [IW-1:0]   hold_id_q, hold_id_d;
  logic            hold_valid_q, hold_valid_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [0:0]      stop_cnt_q, stop_cnt_d;

  logic [7:0]      data_arr [NREQ];
  logic            win_found;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   cand;
  logic            load;

  for (genvar g = 0; g < NREQ; g++) begin : g_data
    assign data_arr[g] = data[8*g +: 8];
  end

  // Round-robin search: first set request at or above ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    gnt_d        = '0;
    cur_id_d     = cur_id_q;
    hold_d       = hold_q;
    hold_id_d    = hold_id_q;
    hold_valid_d = hold_valid_q;
    ptr_d        = ptr_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    load         = 1'b0;

    if (baud_tick) begin
      case (state_q)
        ST_IDLE:  load = hold_valid_q;
        ST_START: begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q == 3'd7) begin
            tx_d       = 1'b1;
            stop_cnt_d = '0;
            state_d    = ST_STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_STOP: begin
          if (stop_cnt_q == STOP_LAST) begin
            if (hold_valid_q) begin
              load = 1'b1;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Frame load empties the holding register; the arbiter only looks at the
    // registered hold_valid, so a refill lands on the following cycle.
    if (load) begin
      tx_d         = 1'b0;
      shift_d      = hold_q;
      cur_id_d     = hold_id_q;
      hold_valid_d = 1'b0;
      state_d      = ST_START;
    end

    if (!hold_valid_q && win_found) begin
      hold_d        = data_arr[win_id];
      hold_id_d     = win_id;
      hold_valid_d  = 1'b1;
      gnt_d[win_id] = 1'b1;
      ptr_d         = (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tx_q         <= 1'b1;
      gnt_q        <= '0;
      cur_id_q     <= '0;
      hold_q       <= '0;
      hold_id_q    <= '0;
      hold_valid_q <= 1'b0;
      ptr_q        <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      gnt_q        <= gnt_d;
      cur_id_q     <= cur_id_d;
      hold_q       <= hold_d;
      hold_id_q    <= hold_id_d;
      hold_valid_q <= hold_valid_d;
      ptr_q        <= ptr_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign tx     = tx_q;
  assign cur_id = cur_id_q;
  assign busy   = (state_q != ST_IDLE) | hold_valid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler. The model treats the line as a queue of bits
// still to be sent and the arbiter as a pointer search over the request
// vector; literal expectations pin grant orders and the line waveforms.
module tb_uart_tx_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1, baud_tick = 1'b0;
  logic [N-1:0]   req = '0, gnt;
  logic [8*N-1:0] data = '0;
  logic           tx, busy;
  logic [1:0]     cur_id;

  logic           reset2 = 1'b1, tick2 = 1'b1;
  logic [N-1:0]   req2 = '0, gnt2;
  logic [8*N-1:0] data2 = '0;
  logic           tx2, busy2;
  logic [1:0]     cur_id2;

  uart_tx_scheduler #(.NREQ(N), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .req(req), .data(data),
    .gnt(gnt), .tx(tx), .busy(busy), .cur_id(cur_id));

  uart_tx_scheduler #(.NREQ(N), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset2), .baud_tick(tick2), .req(req2), .data(data2),
    .gnt(gnt2), .tx(tx2), .busy(busy2), .cur_id(cur_id2));

  int n_vec = 0, n_mis = 0;

  // requester byte queues (ring buffers that only grow within a run)
  logic [7:0]   rbuf [N][64];
  int           rhead [N] = '{default: 0};
  int           rtail [N] = '{default: 0};
  logic [N-1:0] extra_req = '0;
  int           tick_period = 0, tcnt = 0;
  bit           model_on = 0;

  // model state
  logic         m_hv = 0;
  logic [7:0]   m_hold = 0;
  int           m_hid = 0, m_ptr = 0, m_cur = 0;
  bit           m_bits[$];
  logic         m_tx = 1;
  logic [N-1:0] m_gnt = 0;
  bit           m_frame = 0;

  int   got_order[$];
  logic tick_log[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_step();
    logic old_hv;
    bit   found;
    int   i;
    old_hv = m_hv;
    if (reset) begin
      m_hv = 0; m_ptr = 0; m_bits.delete(); m_tx = 1; m_gnt = '0; m_cur = 0; m_frame = 0;
    end else begin
      if (baud_tick) begin
        if (m_bits.size() != 0) begin
          m_tx = m_bits.pop_front();
        end else if (old_hv) begin
          m_tx = 0;
          for (int b = 0; b < 8; b++) m_bits.push_back(m_hold[b]);
          m_bits.push_back(1'b1);
          m_cur = m_hid; m_hv = 0; m_frame = 1;
        end else begin
          m_tx = 1; m_frame = 0;
        end
      end
      m_gnt = '0;
      found = 0;
      if (!old_hv) begin
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + k) % N;
          if (!found && req[i]) begin
            found = 1; m_gnt[i] = 1'b1; m_hold = data[8*i +: 8]; m_hid = i; m_hv = 1;
          end
        end
        if (found) m_ptr = (m_hid + 1) % N;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (tick_period == 0) baud_tick = 1'b0;
    else begin
      tcnt++;
      baud_tick = (tcnt % tick_period) == 0;
    end
    for (int i = 0; i < N; i++) begin
      if (gnt[i] && rhead[i] != rtail[i]) rhead[i]++;
      req[i] = (rhead[i] != rtail[i]) | extra_req[i];
      data[8*i +: 8] = (rhead[i] != rtail[i]) ? rbuf[i][rhead[i] % 64] : 8'hEE;
    end
    @(posedge clk);
    model_step();
    #1;
    if (model_on) begin
      chk("gnt", gnt, m_gnt);
      chk("tx", tx, m_tx);
      chk("busy", busy, m_frame | m_hv);
      chk("cur_id", cur_id, m_cur);
    end
    for (int i = 0; i < N; i++) if (gnt[i]) got_order.push_back(i);
    if (baud_tick) tick_log.push_back(tx);
    #1;
  endtask

  task automatic push(input int id, input logic [7:0] b);
    rbuf[id][rtail[id] % 64] = b;
    rtail[id]++;
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (rhead[i] != rtail[i]) return 1;
    return 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    extra_req = '0;
    for (int i = 0; i < N; i++) rtail[i] = rhead[i];
    repeat (2) cyc();
    chk("rst_tx", tx, 1);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_id", cur_id, 0);
    reset = 1'b0;
    got_order.delete();
    tick_log.delete();
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int c;
    c = 0;
    repeat (3) cyc();
    while ((pending() || busy || m_frame || m_hv) && c < maxc) begin
      cyc();
      c++;
    end
    if (c >= maxc) begin
      n_vec++; n_mis++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, maxc);
    end
  endtask

  task automatic check_order(input string name, input int n, input int eo[16]);
    chk({name, "_count"}, got_order.size(), n);
    for (int k = 0; k < n; k++)
      chk({name, "_order"}, (k < got_order.size()) ? got_order[k] : 99, eo[k]);
  endtask

  function automatic int first_zero();
    for (int k = 0; k < tick_log.size(); k++) if (tick_log[k] == 1'b0) return k;
    return -1000;
  endfunction

  function automatic int logat(input int idx);
    if (idx >= 0 && idx < tick_log.size()) return int'(tick_log[idx]);
    return 9;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int eo[16];
    int s, c;
    int exp_a5[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    int exp_3c[11] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    logic [7:0] b;

    cyc();
    model_on = 1;

    // single byte, tick every 16 clk
    tick_period = 16;
    do_reset();
    push(2, 8'hA5);
    wait_idle("single", 400);
    eo = '{default: 0}; eo[0] = 2;
    check_order("single", 1, eo);
    s = first_zero();
    for (int k = 0; k < 11; k++) chk("single_line", logat(s + k), exp_a5[k]);
    chk("single_cur_id", cur_id, 2);

    // all four at once
    tick_period = 4;
    do_reset();
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44);
    wait_idle("four", 800);
    eo = '{default: 0}; eo[0] = 0; eo[1] = 1; eo[2] = 2; eo[3] = 3;
    check_order("four", 4, eo);
    s = first_zero();
    for (int f = 0; f < 4; f++) begin
      b = 8'h11 * 8'(f + 1);
      chk("four_start", logat(s + 10*f), 0);
      for (int k = 0; k < 8; k++) chk("four_data", logat(s + 10*f + 1 + k), int'(b[k]));
      chk("four_stop", logat(s + 10*f + 9), 1);
    end
    chk("four_idle", logat(s + 40), 1);

    // fairness: 0 and 3 both always requesting
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push(0, 8'(8'h30 + k));
      push(3, 8'(8'hC0 + k));
    end
    wait_idle("fair", 2000);
    eo = '{default: 0};
    for (int k = 0; k < 10; k++) eo[k] = (k % 2 == 0) ? 0 : 3;
    check_order("fair", 10, eo);

    // withdrawn request while the holding register is full
    do_reset();
    push(0, 8'h5A); push(0, 8'h0F); push(2, 8'hC3);
    c = 0;
    do begin cyc(); c++; end while (!(m_hv && m_frame) && c < 200);
    chk("withdraw_hold_full", m_hv && m_frame, 1);
    extra_req = 4'b0010;
    cyc();
    extra_req = '0;
    wait_idle("withdraw", 800);
    eo = '{default: 0}; eo[0] = 0; eo[1] = 2; eo[2] = 0;
    check_order("withdraw", 3, eo);

    // reset during data bit 3
    do_reset();
    push(1, 8'h96);
    c = 0;
    do begin cyc(); c++; s = first_zero(); end while (!(s >= 0 && tick_log.size() >= s + 5) && c < 200);
    chk("midrst_in_frame", busy, 1);
    reset = 1'b1;
    for (int i = 0; i < N; i++) rtail[i] = rhead[i];
    cyc();
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_gnt", gnt, 0);
    reset = 1'b0;
    got_order.delete();
    push(0, 8'h12); push(2, 8'h34);
    wait_idle("midrst", 400);
    eo = '{default: 0}; eo[0] = 0; eo[1] = 2;
    check_order("midrst", 2, eo);

    // maximum tick rate, two stop bits (second instance)
    repeat (2) cyc();
    chk("max_rst_tx", tx2, 1);
    chk("max_rst_busy", busy2, 0);
    reset2 = 1'b0;
    cyc();
    req2 = 4'b0001;
    data2[7:0] = 8'h3C;
    c = 0;
    do begin cyc(); c++; end while (gnt2 == '0 && c < 5);
    chk("max_gnt", gnt2, 4'b0001);
    chk("max_no_early_start", tx2, 1);
    chk("max_busy_hold", busy2, 1);
    req2 = '0;
    for (int k = 0; k < 11; k++) begin
      cyc();
      chk("max_line", tx2, exp_3c[k]);
    end
    chk("max_busy_last_stop", busy2, 1);
    cyc();
    chk("max_busy_end", busy2, 0);
    chk("max_cur_id", cur_id2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares one UART transmit line among NREQ byte requesters. Round-robin arbitration selects a requester into a one-entry holding register. A frame sequencer then shifts each byte out as 8N1-style frames, paced by the baud tick derived from the baud rate generator. It sits between the system-side byte producers and the serial `tx` pin, and owns all sequencing of the transmit path.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 1..16.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `baud_tick`  in  1  one-`clk`-cycle pulse per bit period, produced from the baud rate generator's `bclk`; ignored while `reset`=1.
- `req`  in  NREQ  per-requester byte request; hold high with stable data until granted.
- `data`  in  8*NREQ  requester i's byte on bits [8i+7:8i].
- `gnt`  out  NREQ  registered one-cycle grant pulse, one-hot.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while the holding register is full or a frame is in progress.
- `cur_id`  out  clog2(NREQ) (min 1)  id of the requester whose byte is currently shifting.

## Operation
- Reset values: `tx`=1, `gnt`=0, `busy`=0, `cur_id`=0, `hold_valid`=0, round-robin pointer `ptr`=0, state IDLE.
- **Arbiter:**
  - Evaluates every cycle that `hold_valid`=0 and `req`≠0.
  - Winner w is the first set `req` bit searching from `ptr` upward, wrapping modulo NREQ.
  - At that edge: `hold`←`data[w]`, `hold_id`←w, `hold_valid`←1, `gnt[w]`←1 (for one cycle), `ptr`←(w+1) mod NREQ.
  - No evaluation while `hold_valid`=1.
- **Request rules:**
  - A requester drops `req` in the cycle it sees `gnt`, or keeps it high to request another byte.
  - A `req` withdrawn before capture is never granted and never consumes the pointer.
- **Sequencer states:** IDLE, START, DATA, STOP. Transitions occur only on edges where `baud_tick`=1.
  - IDLE, `hold_valid`=1: `tx`←0, shifter←`hold`, `cur_id`←`hold_id`, `hold_valid`←0, go to START.
  - START → DATA: `tx`←shifter[0], bit count←0.
  - DATA: shift right; `tx`←next bit, LSB first. After bit 7 has been driven for one period: `tx`←1, go to STOP.
  - STOP, final stop period ending, `hold_valid`=1: go directly to START as in IDLE. No idle bits between frames.
  - STOP, final stop period ending, `hold_valid`=0: go to IDLE, `tx` stays 1.
- **`busy`:** `busy` = (state≠IDLE) | `hold_valid`.
- **`cur_id`:** holds its last value in IDLE.
- **Simultaneous events:**
  - Capture and `baud_tick` on the same edge in IDLE: the capture is taken and the frame starts on the next tick, never the same one.
  - The `hold_valid` clear at frame load and re-arbitration happen on consecutive cycles. The new capture occurs the cycle after the load.
- **Reset mid-frame:** frame is aborted, holding byte discarded, all registers return to reset values at the reset edge, `tx`=1 from the next cycle.

## Timing
- Grant latency: `gnt` is high in the cycle after the request is seen, with `hold_valid`=0.
- Start latency: start bit begins at the first `baud_tick` edge strictly after the capture edge.
- Each bit (start, 8 data, stop) lasts exactly one tick-to-tick period.
- Frame length: (10 + STOP_BITS − 1) bit periods.
- Back-to-back throughput: one frame per frame-time, provided the next request arrives before the final stop period ends.
- Fastest supported tick: `baud_tick` high every cycle, giving 1 clk per bit.

## Test plan
- **Single byte.** NREQ=4, tick every 16 clk; `req[2]`=1 with byte 0xA5.
  - `gnt`=4'b0100 for one cycle.
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each 16 clk, starting at the next tick.
  - `cur_id`=2; `busy` falls when the stop period ends.
- **All four request at once.** Bytes 0x11, 0x22, 0x33, 0x44 on requesters 0..3, each held until granted.
  - Grants in order 0,1,2,3.
  - Four contiguous frames: 40 bit periods with no idle high bits between frames.
- **Fairness.** `req[0]` and `req[3]` held high continuously with new data after each grant.
  - Grants alternate 0,3,0,3 for at least 8 frames.
- **Withdrawn request.** `req[1]` pulsed high for 1 cycle while `hold_valid`=1.
  - No `gnt[1]`, no extra frame, `ptr` unchanged (next grant order unaffected).
- **Reset mid-frame.** Reset asserted during data bit 3.
  - `tx`=1, `busy`=0, `gnt`=0 after the reset edge.
  - Then `req[0]` and `req[2]` simultaneously: requester 0 granted first.
- **Maximum tick rate.** `baud_tick` tied high, byte 0x3C, STOP_BITS=2.
  - `tx` = 0,0,0,1,1,1,1,0,0,1,1, one clk per bit.
  - Capture-plus-tick edge does not start the frame early.
